ctrl_pipe: RTL and testbench

- Receives the main decoder's control bits and register fields for the instruction in ID.
- Carries the controls through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects RAW hazards and drives stall and bubble insertion, plus IF/ID flush for jumps and taken branches.
- Sits between the ID-stage decoder and the EX/MEM/WB datapath; it is the consumer end of the decoder's control bus.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/hazard_unit.sv | 72 +++++++
 rtl/ctrl_pipe.sv | 143 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared widths, forward-select encodings and pipeline control bundles for ctrl_pipe.
package ctrl_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned ALUOP_W = 2;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef struct packed {
      logic               regdst;
      logic               alusrc;
      logic               memtoreg;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic               jump;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   typedef struct packed {
      logic             valid;
      ctrl_t            ctrl;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] wreg;
   } idex_t;

   typedef struct packed {
      logic             valid;
      logic             memtoreg;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic [REG_W-1:0] wreg;
   } exmem_t;

   typedef struct packed {
      logic             valid;
      logic             memtoreg;
      logic             regwrite;
      logic [REG_W-1:0] wreg;
   } memwb_t;

   // Register 0 is hardwired, so a write to it never produces a dependence.
   function automatic logic writes_reg(input logic             valid,
                                       input logic             regwrite,
                                       input logic [REG_W-1:0] wreg,
                                       input logic [REG_W-1:0] src);
      return valid & regwrite & (wreg != '0) & (wreg == src);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational RAW stall and ALU forward-select logic.
// FORWARD_EN selects EX-stage forwarding; otherwise EX/MEM producers stall ID.
module hazard_unit
   import ctrl_pkg::*;
(
   input  logic             id_valid,
   input  logic             id_alusrc,
   input  logic             id_memwrite,
   input  logic             id_branch,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_valid,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_wreg,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_valid,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] mem_wreg,
   input  logic             wb_valid,
   input  logic             wb_regwrite,
   input  logic [REG_W-1:0] wb_wreg,
   input  logic             squash,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   logic rt_used;
   logic ex_hit;
   logic load_use;
   logic hazard;

   assign rt_used  = !id_alusrc | id_memwrite | id_branch;
   assign ex_hit   = writes_reg(ex_valid, ex_regwrite, ex_wreg, id_rs)
                   | (rt_used & writes_reg(ex_valid, ex_regwrite, ex_wreg, id_rt));
   assign load_use = ex_memread & ex_hit;

`ifdef FORWARD_EN
   assign hazard = load_use;

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (writes_reg(mem_valid, mem_regwrite, mem_wreg, ex_rs)) begin
         fwd_a = FWD_MEM;
      end else if (writes_reg(wb_valid, wb_regwrite, wb_wreg, ex_rs)) begin
         fwd_a = FWD_WB;
      end
      if (writes_reg(mem_valid, mem_regwrite, mem_wreg, ex_rt)) begin
         fwd_b = FWD_MEM;
      end else if (writes_reg(wb_valid, wb_regwrite, wb_wreg, ex_rt)) begin
         fwd_b = FWD_WB;
      end
   end
`else
   logic mem_hit;
   logic unused_fwd_inputs;

   // WB is not checked: the register file writes before ID reads it.
   assign mem_hit = writes_reg(mem_valid, mem_regwrite, mem_wreg, id_rs)
                  | (rt_used & writes_reg(mem_valid, mem_regwrite, mem_wreg, id_rt));
   assign hazard  = load_use | ex_hit | mem_hit;
   assign fwd_a   = FWD_RF;
   assign fwd_b   = FWD_RF;
   assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_valid, wb_regwrite, wb_wreg};
`endif

   assign stall = id_valid & hazard & !squash;

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with stall, bubble and IF/ID flush.
// Optional macro FORWARD_EN enables EX-stage operand forwarding.
module ctrl_pipe
   import ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic               id_regdst,
   input  logic               id_alusrc,
   input  logic               id_memtoreg,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_branch,
   input  logic               id_jump,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               ex_branch_taken,
   output logic               stall,
   output logic               flush_ifid,
   output logic               ex_regdst,
   output logic               ex_alusrc,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic               ex_branch,
   output logic               mem_memread,
   output logic               mem_memwrite,
   output logic               wb_memtoreg,
   output logic               wb_regwrite,
   output logic [REG_W-1:0]   ex_wreg,
   output logic [REG_W-1:0]   mem_wreg,
   output logic [REG_W-1:0]   wb_wreg,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b
);

   idex_t  idex_q,  idex_d;
   exmem_t exmem_q, exmem_d;
   memwb_t memwb_q, memwb_d;
   ctrl_t  id_ctrl;
   logic   taken;
   logic   bubble;
   logic   unused_jump;

   assign id_ctrl = '{regdst:   id_regdst,
                      alusrc:   id_alusrc,
                      memtoreg: id_memtoreg,
                      regwrite: id_regwrite,
                      memread:  id_memread,
                      memwrite: id_memwrite,
                      branch:   id_branch,
                      jump:     id_jump,
                      aluop:    id_aluop};

   assign taken = idex_q.valid & idex_q.ctrl.branch & ex_branch_taken;

   hazard_unit u_hazard (
      .id_valid     (id_valid),
      .id_alusrc    (id_alusrc),
      .id_memwrite  (id_memwrite),
      .id_branch    (id_branch),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_valid     (idex_q.valid),
      .ex_regwrite  (idex_q.ctrl.regwrite),
      .ex_memread   (idex_q.ctrl.memread),
      .ex_wreg      (idex_q.wreg),
      .ex_rs        (idex_q.rs),
      .ex_rt        (idex_q.rt),
      .mem_valid    (exmem_q.valid),
      .mem_regwrite (exmem_q.regwrite),
      .mem_wreg     (exmem_q.wreg),
      .wb_valid     (memwb_q.valid),
      .wb_regwrite  (memwb_q.regwrite),
      .wb_wreg      (memwb_q.wreg),
      .squash       (taken),
      .stall        (stall),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   // A taken branch squashes whatever is in ID, including a jump.
   assign flush_ifid = taken | (id_valid & id_jump & !stall);
   assign bubble     = stall | !id_valid | taken;

   always_comb begin
      idex_d = '0;
      if (!bubble) begin
         idex_d.valid = 1'b1;
         idex_d.ctrl  = id_ctrl;
         idex_d.rs    = id_rs;
         idex_d.rt    = id_rt;
         idex_d.wreg  = id_regdst ? id_rd : id_rt;
      end
   end

   always_comb begin
      exmem_d          = '0;
      exmem_d.valid    = idex_q.valid;
      exmem_d.memtoreg = idex_q.ctrl.memtoreg;
      exmem_d.regwrite = idex_q.ctrl.regwrite;
      exmem_d.memread  = idex_q.ctrl.memread;
      exmem_d.memwrite = idex_q.ctrl.memwrite;
      exmem_d.wreg     = idex_q.wreg;
   end

   always_comb begin
      memwb_d          = '0;
      memwb_d.valid    = exmem_q.valid;
      memwb_d.memtoreg = exmem_q.memtoreg;
      memwb_d.regwrite = exmem_q.regwrite;
      memwb_d.wreg     = exmem_q.wreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   assign ex_regdst    = idex_q.ctrl.regdst;
   assign ex_alusrc    = idex_q.ctrl.alusrc;
   assign ex_aluop     = idex_q.ctrl.aluop;
   assign ex_branch    = idex_q.ctrl.branch;
   assign ex_wreg      = idex_q.wreg;
   assign mem_memread  = exmem_q.memread;
   assign mem_memwrite = exmem_q.memwrite;
   assign mem_wreg     = exmem_q.wreg;
   assign wb_memtoreg  = memwb_q.memtoreg;
   assign wb_regwrite  = memwb_q.regwrite;
   assign wb_wreg      = memwb_q.wreg;

   assign unused_jump = idex_q.ctrl.jump;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations follow FORWARD_EN when it is defined.
module tb_ctrl_pipe;
   import ctrl_pkg::*;

`ifdef FORWARD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite;
   logic               id_memread, id_memwrite, id_branch, id_jump;
   logic [ALUOP_W-1:0] id_aluop;
   logic [REG_W-1:0]   id_rs, id_rt, id_rd;
   logic               ex_branch_taken;
   logic               stall, flush_ifid;
   logic               ex_regdst, ex_alusrc, ex_branch;
   logic [ALUOP_W-1:0] ex_aluop;
   logic               mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite;
   logic [REG_W-1:0]   ex_wreg, mem_wreg, wb_wreg;
   logic [1:0]         fwd_a, fwd_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_regdst       (id_regdst),
      .id_alusrc       (id_alusrc),
      .id_memtoreg     (id_memtoreg),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .id_memwrite     (id_memwrite),
      .id_branch       (id_branch),
      .id_jump         (id_jump),
      .id_aluop        (id_aluop),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_rd           (id_rd),
      .ex_branch_taken (ex_branch_taken),
      .stall           (stall),
      .flush_ifid      (flush_ifid),
      .ex_regdst       (ex_regdst),
      .ex_alusrc       (ex_alusrc),
      .ex_aluop        (ex_aluop),
      .ex_branch       (ex_branch),
      .mem_memread     (mem_memread),
      .mem_memwrite    (mem_memwrite),
      .wb_memtoreg     (wb_memtoreg),
      .wb_regwrite     (wb_regwrite),
      .ex_wreg         (ex_wreg),
      .mem_wreg        (mem_wreg),
      .wb_wreg         (wb_wreg),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic rd_sel, input logic asrc, input logic m2r,
                         input logic rw, input logic mr, input logic mw, input logic br,
                         input logic jp, input logic [1:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
      id_valid    = v;
      id_regdst   = rd_sel;
      id_alusrc   = asrc;
      id_memtoreg = m2r;
      id_regwrite = rw;
      id_memread  = mr;
      id_memwrite = mw;
      id_branch   = br;
      id_jump     = jp;
      id_aluop    = op;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
   endtask

   task automatic id_nop();
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
   endtask
   task automatic id_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_set(1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b10, rs, rt, rd);
   endtask
   task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
      id_set(1, 0, 1, 1, 1, 1, 0, 0, 0, 2'b00, rs, rt, 5'd0);
   endtask
   task automatic id_addi(input logic [4:0] rs, input logic [4:0] rt);
      id_set(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, rs, rt, 5'd0);
   endtask
   task automatic id_sw(input logic [4:0] rs, input logic [4:0] rt);
      id_set(1, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, rs, rt, 5'd0);
   endtask
   task automatic id_beq(input logic [4:0] rs, input logic [4:0] rt);
      id_set(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, rs, rt, 5'd0);
   endtask
   task automatic id_jmp(input logic [4:0] rs);
      id_set(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, rs, 5'd0, 5'd0);
   endtask

   task automatic drain();
      id_nop();
      ex_branch_taken = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      reset = 1'b1;
      ex_branch_taken = 1'b0;
      id_rtype(5'd1, 5'd2, 5'd3);

      // Reset held with a live R-type in ID
      tick();
      tick();
      check_eq("reset_all",
               {2'b0, ex_regdst, ex_alusrc, ex_aluop, ex_branch, mem_memread, mem_memwrite,
                wb_memtoreg, wb_regwrite, ex_wreg, mem_wreg, wb_wreg, fwd_a, fwd_b, stall,
                flush_ifid}, 32'd0);

      reset = 1'b0;
      tick();
      id_nop();
      #1;
      check_eq("rst_ex_regdst", ex_regdst, 1);
      check_eq("rst_ex_aluop", ex_aluop, 2'b10);
      check_eq("rst_ex_wreg", ex_wreg, 3);
      check_eq("rst_wb_early", wb_regwrite, 0);
      tick();
      check_eq("rst_mem_wreg", mem_wreg, 3);
      check_eq("rst_wb_mid", wb_regwrite, 0);
      tick();
      check_eq("rst_wb_regwrite", wb_regwrite, 1);
      check_eq("rst_wb_wreg", wb_wreg, 3);
      drain();

      // Load-use: lw $8 then add rs=8
      id_lw(5'd1, 5'd8);
      tick();
      id_rtype(5'd8, 5'd2, 5'd10);
      #1;
      check_eq("lu_stall0", stall, 1);
      check_eq("lu_flush", flush_ifid, 0);
      tick();
      check_eq("lu_bubble", {ex_regdst, ex_aluop, ex_wreg}, 0);
      check_eq("lu_stall1", stall, FwdEn ? 0 : 1);
`ifndef FORWARD_EN
      tick();
      check_eq("lu_stall2", stall, 0);
`endif
      tick();
      check_eq("lu_issue", ex_wreg, 10);
      check_eq("lu_fwd_a", fwd_a, FwdEn ? 2'b01 : 2'b00);
      drain();

      // Register 0 never creates a hazard
      id_lw(5'd1, 5'd0);
      tick();
      id_rtype(5'd0, 5'd0, 5'd10);
      #1;
      check_eq("r0_stall", stall, 0);
      drain();

      // rt use rules and invalid ID
      id_lw(5'd1, 5'd8);
      tick();
      id_addi(5'd1, 5'd8);
      #1;
      check_eq("rt_unused", stall, 0);
      id_sw(5'd1, 5'd8);
      #1;
      check_eq("rt_sw", stall, 1);
      id_rtype(5'd8, 5'd2, 5'd10);
      id_valid = 1'b0;
      #1;
      check_eq("inv_stall", stall, 0);
      drain();

      // add $9, sub rs=9
      id_rtype(5'd1, 5'd2, 5'd9);
      tick();
      id_rtype(5'd9, 5'd2, 5'd11);
      #1;
      check_eq("fa_stall", stall, FwdEn ? 0 : 1);
`ifndef FORWARD_EN
      tick();
      check_eq("fa_stall_mem", stall, 1);
      tick();
      check_eq("fa_stall_wb", stall, 0);
`endif
      tick();
      check_eq("fa_issue", ex_wreg, 11);
      check_eq("fa_fwd_a", fwd_a, FwdEn ? 2'b10 : 2'b00);
      check_eq("fa_fwd_b", fwd_b, 2'b00);
      drain();

      // add $9, nop, sub rt=9
      id_rtype(5'd1, 5'd2, 5'd9);
      tick();
      id_nop();
      tick();
      id_rtype(5'd3, 5'd9, 5'd12);
      #1;
      check_eq("fb_stall", stall, FwdEn ? 0 : 1);
`ifndef FORWARD_EN
      tick();
      check_eq("fb_stall_wb", stall, 0);
`endif
      tick();
      check_eq("fb_issue", ex_wreg, 12);
      check_eq("fb_fwd_b", fwd_b, FwdEn ? 2'b01 : 2'b00);
      check_eq("fb_fwd_a", fwd_a, 2'b00);
      drain();

      // Taken branch in EX overrides a stall in ID
      id_lw(5'd1, 5'd8);
      tick();
      id_beq(5'd3, 5'd4);
      tick();
      id_rtype(5'd8, 5'd2, 5'd13);
      ex_branch_taken = 1'b0;
      #1;
      check_eq("br_ex_branch", ex_branch, 1);
      check_eq("br_stall_nt", stall, FwdEn ? 0 : 1);
      check_eq("br_flush_nt", flush_ifid, 0);
      ex_branch_taken = 1'b1;
      #1;
      check_eq("br_flush", flush_ifid, 1);
      check_eq("br_stall_t", stall, 0);
      tick();
      ex_branch_taken = 1'b0;
      id_nop();
      #1;
      check_eq("br_squash", {ex_regdst, ex_alusrc, ex_aluop, ex_branch, ex_wreg}, 0);
      drain();

      // Jump flushes IF/ID and writes nothing
      id_jmp(5'd0);
      #1;
      check_eq("j_flush", flush_ifid, 1);
      check_eq("j_stall", stall, 0);
      tick();
      id_nop();
      #1;
      check_eq("j_ex", {ex_regdst, ex_alusrc, ex_aluop, ex_branch}, 0);
      tick();
      tick();
      check_eq("j_nowb", wb_regwrite, 0);
      drain();

      // Jump behind a producer of its rs
      id_rtype(5'd1, 5'd2, 5'd9);
      tick();
      id_jmp(5'd9);
      #1;
      check_eq("js_stall", stall, FwdEn ? 0 : 1);
      check_eq("js_flush", flush_ifid, FwdEn ? 1 : 0);
      drain();

      // Taken branch and jump together: branch wins
      id_beq(5'd1, 5'd2);
      tick();
      id_jmp(5'd0);
      ex_branch_taken = 1'b1;
      #1;
      check_eq("bj_flush", flush_ifid, 1);
      tick();
      ex_branch_taken = 1'b0;
      id_nop();
      #1;
      check_eq("bj_squash", {ex_regdst, ex_alusrc, ex_aluop, ex_branch, ex_wreg}, 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
